// File: rtl/issue_queue_if.sv
// Shared rename/issue types and the handshake interface between rename, wakeup,
// branch resolution and the issue queue.
package issue_queue_pkg;
    localparam int PHYS_IDX_W = 6;

    typedef struct packed {
        logic                  valid;
        logic [PHYS_IDX_W-1:0] idx;
    } p_reg_t;

    typedef struct packed {
        logic                  valid;
        logic                  ready;
        logic [PHYS_IDX_W-1:0] idx;
    } src_t;

    typedef struct packed {
        logic       valid;
        logic [6:0] opcode;
        p_reg_t     rd;
        src_t       rs1;
        src_t       rs2;
    } rinstr_t;

    typedef struct packed {
        logic valid;
        logic hit;
    } br_result_t;
endpackage

interface issue_queue_if;
    import issue_queue_pkg::*;

    rinstr_t    rinstr;
    logic       rn_is_branch;
    p_reg_t     p_commit;
    br_result_t br_result;
    rinstr_t    issue;
    logic       issue_valid;
    logic       issue_ready;
    logic       iq_full;
    logic       iq_empty;

    modport master (
        output rinstr, rn_is_branch, p_commit, br_result, issue_ready,
        input  issue, issue_valid, iq_full, iq_empty
    );

    modport slave (
        input  rinstr, rn_is_branch, p_commit, br_result, issue_ready,
        output issue, issue_valid, iq_full, iq_empty
    );
endinterface

// File: rtl/issue_queue.sv
// Collapsing out-of-order issue queue: in-order allocate, oldest-ready issue,
// wakeup on commit and single-branch speculative squash.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int P_IDX_W = PHYS_IDX_W,
    parameter int CNT_W   = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst_i,
    issue_queue_if.slave io
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        rinstr_t payload;
        logic    rs1_rdy;
        logic    rs2_rdy;
        logic    spec;
        logic    is_branch;
    } entry_t;

    entry_t             ent_reg  [DEPTH];
    entry_t             ent_next [DEPTH];
    logic [DEPTH-1:0]   valid_reg;
    logic [DEPTH-1:0]   valid_next;
    logic [CNT_W-1:0]   count_reg;
    logic [CNT_W-1:0]   count_next;
    logic               branch_pending_reg;
    logic               branch_pending_next;

    logic               commit_valid;
    logic [P_IDX_W-1:0] commit_idx;
    logic               br_resolve;
    logic               br_hit;
    logic               br_miss;
    logic               full;
    logic               enq_req;
    logic               enq_accept;
    entry_t             new_entry;

    logic [DEPTH-1:0]   wake1;
    logic [DEPTH-1:0]   wake2;
    logic [DEPTH-1:0]   rdy_vec;
    logic [DEPTH-1:0]   squash_vec;
    logic [DEPTH-1:0]   bad_vec;

    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic               fire;
    rinstr_t            issue_pl;

    entry_t             e_tmp;
    logic [CNT_W-1:0]   pos;

    assign commit_valid = io.p_commit.valid;
    assign commit_idx   = io.p_commit.idx;

    assign br_resolve = io.br_result.valid && branch_pending_reg;
    assign br_hit     = br_resolve && io.br_result.hit;
    assign br_miss    = br_resolve && !io.br_result.hit;

    assign full        = (count_reg == CNT_W'(DEPTH));
    assign io.iq_full  = full;
    assign io.iq_empty = (count_reg == '0);

    // A wrong-path arrival is dropped, never stored.
    assign enq_req    = io.rinstr.valid && !full;
    assign enq_accept = enq_req && !br_miss;

    always_comb begin
        new_entry         = '0;
        new_entry.payload = io.rinstr;
        new_entry.rs1_rdy = !io.rinstr.rs1.valid || io.rinstr.rs1.ready
                            || (commit_valid && (commit_idx == io.rinstr.rs1.idx));
        new_entry.rs2_rdy = !io.rinstr.rs2.valid || io.rinstr.rs2.ready
                            || (commit_valid && (commit_idx == io.rinstr.rs2.idx));
        new_entry.spec      = branch_pending_reg && !br_resolve;
        new_entry.is_branch = io.rn_is_branch;
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign wake1[gi] = commit_valid && (commit_idx == ent_reg[gi].payload.rs1.idx);
            assign wake2[gi] = commit_valid && (commit_idx == ent_reg[gi].payload.rs2.idx);
            // Selection sees stored ready bits only; spec entries are blocked while being squashed.
            assign rdy_vec[gi] = valid_reg[gi] && ent_reg[gi].rs1_rdy && ent_reg[gi].rs2_rdy
                                 && !(br_miss && ent_reg[gi].spec);
            assign squash_vec[gi] = valid_reg[gi] && br_miss && ent_reg[gi].spec;
            assign bad_vec[gi]    = valid_reg[gi] && ent_reg[gi].spec && ent_reg[gi].is_branch;
        end
    endgenerate

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!sel_found && rdy_vec[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    assign fire = sel_found && io.issue_ready;

    always_comb begin
        issue_pl = '0;
        if (sel_found) begin
            issue_pl           = ent_reg[sel_idx].payload;
            issue_pl.valid     = 1'b1;
            issue_pl.rs1.ready = 1'b1;
            issue_pl.rs2.ready = 1'b1;
        end
    end

    assign io.issue       = issue_pl;
    assign io.issue_valid = sel_found;

    // Survivors are packed down in age order, then the new arrival lands right behind them.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_next[i] = ent_reg[i];
        end
        valid_next = '0;
        pos        = '0;
        e_tmp      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_reg[i] && !squash_vec[i] && !(fire && (sel_idx == IDX_W'(i)))) begin
                e_tmp         = ent_reg[i];
                e_tmp.rs1_rdy = e_tmp.rs1_rdy | wake1[i];
                e_tmp.rs2_rdy = e_tmp.rs2_rdy | wake2[i];
                if (br_hit) begin
                    e_tmp.spec = 1'b0;
                end
                ent_next[pos[IDX_W-1:0]]   = e_tmp;
                valid_next[pos[IDX_W-1:0]] = 1'b1;
                pos = pos + CNT_W'(1);
            end
        end
        if (enq_accept) begin
            ent_next[pos[IDX_W-1:0]]   = new_entry;
            valid_next[pos[IDX_W-1:0]] = 1'b1;
            pos = pos + CNT_W'(1);
        end
        count_next = pos;
    end

    always_comb begin
        branch_pending_next = branch_pending_reg;
        if (br_resolve) begin
            branch_pending_next = 1'b0;
        end else if (enq_accept && io.rn_is_branch) begin
            branch_pending_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            valid_reg          <= '0;
            count_reg          <= '0;
            branch_pending_reg <= 1'b0;
        end else begin
            valid_reg          <= valid_next;
            count_reg          <= count_next;
            branch_pending_reg <= branch_pending_next;
        end
    end

    // Payload needs no reset: valid_reg alone decides whether a slot means anything.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_reg[i] <= ent_next[i];
        end
    end

    a_no_nested_branch: assert property (@(posedge clk) disable iff (rst_i)
        !(enq_req && io.rn_is_branch && branch_pending_reg));
    a_count_range: assert property (@(posedge clk) disable iff (rst_i)
        count_reg <= CNT_W'(DEPTH));
    a_branch_not_spec: assert property (@(posedge clk) disable iff (rst_i)
        bad_vec == '0);

endmodule

// File: tb/tb_issue_queue.sv
// Directed, table-driven bench for issue_queue with a few hand-written sequences.
module tb_issue_queue;
    import issue_queue_pkg::*;

    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    issue_queue_if io();

    issue_queue #(.DEPTH(8), .P_IDX_W(6), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_i (rst_i),
        .io    (io)
    );

    typedef struct {
        int rst, en, rd, s1, r1, s2, r2, br;
        int cv, ci, bv, bh, irdy;
        int eiv, erd, ecnt, ebp;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic add(input int rst, en, rd, s1, r1, s2, r2, br,
                       input int cv, ci, bv, bh, irdy,
                       input int eiv, erd, ecnt, ebp);
        vec_t v;
        v.rst = rst; v.en = en; v.rd = rd; v.s1 = s1; v.r1 = r1; v.s2 = s2; v.r2 = r2; v.br = br;
        v.cv = cv; v.ci = ci; v.bv = bv; v.bh = bh; v.irdy = irdy;
        v.eiv = eiv; v.erd = erd; v.ecnt = ecnt; v.ebp = ebp;
        vecs.push_back(v);
    endtask

    // Source index 0 means "no source" (valid=0, ready=0 as delivered by rename).
    function automatic rinstr_t mk_instr(input int rd, s1, r1, s2, r2);
        rinstr_t r;
        r           = '0;
        r.valid     = 1'b1;
        r.opcode    = 7'h33;
        r.rd.valid  = 1'b1;
        r.rd.idx    = 6'(rd);
        r.rs1.valid = (s1 != 0);
        r.rs1.ready = (r1 != 0);
        r.rs1.idx   = 6'(s1);
        r.rs2.valid = (s2 != 0);
        r.rs2.ready = (r2 != 0);
        r.rs2.idx   = 6'(s2);
        return r;
    endfunction

    task automatic chk(input string nm, input int vi, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s vec=%0d got=%0d expected=%0d", nm, vi, act, exp);
        end
    endtask

    task automatic idle_inputs();
        io.rinstr       = '0;
        io.rn_is_branch = 1'b0;
        io.p_commit     = '0;
        io.br_result    = '0;
        io.issue_ready  = 1'b0;
    endtask

    task automatic apply(input vec_t v);
        rst_i               = (v.rst != 0);
        io.rinstr           = (v.en != 0) ? mk_instr(v.rd, v.s1, v.r1, v.s2, v.r2) : '0;
        io.rn_is_branch     = (v.en != 0) && (v.br != 0);
        io.p_commit.valid   = (v.cv != 0);
        io.p_commit.idx     = 6'(v.ci);
        io.br_result.valid  = (v.bv != 0);
        io.br_result.hit    = (v.bh != 0);
        io.issue_ready      = (v.irdy != 0);
    endtask

    initial begin
        int n;
        rst_i = 1'b1;
        idle_inputs();

        // rst en rd s1 r1 s2 r2 br | cv ci bv bh irdy | eiv erd ecnt ebp  (expectations are pre-edge)
        add(0,1,33, 1,1, 2,1, 0,  0, 0, 0,0, 0,  0, 0, 0,0);
        add(0,0, 0, 0,0, 0,0, 0,  0, 0, 0,0, 1,  1,33, 1,0);
        add(0,0, 0, 0,0, 0,0, 0,  0, 0, 0,0, 0,  0, 0, 0,0);
        // older A waits on p40, younger B issues first, then A after wakeup
        add(0,1,34,40,0, 0,0, 0,  0, 0, 0,0, 1,  0, 0, 0,0);
        add(0,1,35, 3,1, 4,1, 0,  0, 0, 0,0, 1,  0, 0, 1,0);
        add(0,0, 0, 0,0, 0,0, 0,  0, 0, 0,0, 1,  1,35, 2,0);
        add(0,0, 0, 0,0, 0,0, 0,  1,40, 0,0, 1,  0, 0, 1,0);
        add(0,0, 0, 0,0, 0,0, 0,  0, 0, 0,0, 1,  1,34, 1,0);
        // wakeup in the enqueue cycle
        add(0,1,36,45,0, 5,1, 0,  1,45, 0,0, 1,  0, 0, 0,0);
        add(0,0, 0, 0,0, 0,0, 0,  0, 0, 0,0, 1,  1,36, 1,0);
        // fill to eight with blocked entries
        for (int k = 0; k < 8; k++) begin
            add(0,1,10+k,50+k,0, 0,0, 0, 0,0, 0,0, 0, 0,0, k,0);
        end
        add(0,1,18, 7,1, 0,0, 0,  0, 0, 0,0, 0,  0, 0, 8,0);
        add(0,0, 0, 0,0, 0,0, 0,  1,52, 0,0, 1,  0, 0, 8,0);
        add(0,1,19, 8,1, 0,0, 0,  0, 0, 0,0, 1,  1,12, 8,0);
        add(0,0, 0, 0,0, 0,0, 0,  0, 0, 0,0, 0,  0, 0, 7,0);
        add(1,0, 0, 0,0, 0,0, 0,  0, 0, 0,0, 0,  0, 0, 0,0);
        // mispredict: branch blocked on p60, three spec entries squashed, same-cycle arrival dropped
        add(0,1,20,60,0, 6,1, 1,  0, 0, 0,0, 0,  0, 0, 0,0);
        add(0,1,21, 9,1, 0,0, 0,  0, 0, 0,0, 0,  0, 0, 1,1);
        add(0,1,22, 9,1, 0,0, 0,  0, 0, 0,0, 0,  1,21, 2,1);
        add(0,1,23, 9,1, 0,0, 0,  0, 0, 0,0, 0,  1,21, 3,1);
        add(0,1,24, 9,1, 0,0, 0,  0, 0, 1,0, 0,  0, 0, 4,1);
        add(0,0, 0, 0,0, 0,0, 0,  1,60, 0,0, 0,  0, 0, 1,0);
        add(0,0, 0, 0,0, 0,0, 0,  0, 0, 0,0, 1,  1,20, 1,0);
        // correct prediction keeps entries and clears spec; a later squash must spare them
        add(0,1,25,61,0, 0,0, 1,  0, 0, 0,0, 0,  0, 0, 0,0);
        add(0,1,26, 9,1, 0,0, 0,  0, 0, 0,0, 0,  0, 0, 1,1);
        add(0,1,27, 9,1, 0,0, 0,  0, 0, 0,0, 0,  1,26, 2,1);
        add(0,1,28, 9,1, 0,0, 0,  0, 0, 0,0, 0,  1,26, 3,1);
        add(0,0, 0, 0,0, 0,0, 0,  0, 0, 1,1, 0,  1,26, 4,1);
        add(0,1,30,62,0, 0,0, 1,  0, 0, 1,0, 0,  1,26, 4,0);
        add(0,1,31, 9,1, 0,0, 0,  0, 0, 0,0, 0,  1,26, 5,1);
        add(0,0, 0, 0,0, 0,0, 0,  0, 0, 1,0, 0,  1,26, 6,1);
        add(0,0, 0, 0,0, 0,0, 0,  0, 0, 0,0, 0,  1,26, 5,0);
        // reset with five entries and an issuable head
        add(1,0, 0, 0,0, 0,0, 0,  0, 0, 0,0, 1,  0, 0, 0,0);
        // enqueue and issue in the same cycle
        add(0,1,40, 9,1, 0,0, 0,  0, 0, 0,0, 1,  0, 0, 0,0);
        add(0,1,41, 9,1, 0,0, 0,  0, 0, 0,0, 1,  1,40, 1,0);
        add(0,0, 0, 0,0, 0,0, 0,  0, 0, 0,0, 0,  1,41, 1,0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_issue_valid", -1, int'(io.issue_valid), 0);
        chk("rst_issue_bus",   -1, int'(io.issue), 0);
        chk("rst_empty",       -1, int'(io.iq_empty), 1);
        chk("rst_full",        -1, int'(io.iq_full), 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            apply(vecs[i]);
            @(negedge clk);
            chk("issue_valid", i, int'(io.issue_valid), vecs[i].eiv);
            chk("count",       i, int'(dut.count_reg), vecs[i].ecnt);
            chk("full",        i, int'(io.iq_full), int'(vecs[i].ecnt == 8));
            chk("empty",       i, int'(io.iq_empty), int'(vecs[i].ecnt == 0));
            chk("br_pending",  i, int'(dut.branch_pending_reg), vecs[i].ebp);
            if (vecs[i].eiv != 0) begin
                chk("issue_rd",  i, int'(io.issue.rd.idx), vecs[i].erd);
                chk("issue_rdy", i, int'({io.issue.valid, io.issue.rs1.ready, io.issue.rs2.ready}), 7);
            end
            $display("vec %0d: rst=%0d en=%0d rd=%0d issue_valid=%0d issue_rd=%0d count=%0d",
                     i, vecs[i].rst, vecs[i].en, vecs[i].rd, io.issue_valid, io.issue.rd.idx, dut.count_reg);
        end

        // Wakeup latency: commit in cycle N makes the entry issuable in cycle N+1.
        @(posedge clk); #1;
        idle_inputs();
        rst_i = 1'b1;
        @(posedge clk); #1;
        rst_i = 1'b0;
        io.rinstr      = mk_instr(50, 20, 0, 0, 0);
        io.issue_ready = 1'b1;
        @(posedge clk); #1;
        io.rinstr         = '0;
        io.p_commit.valid = 1'b1;
        io.p_commit.idx   = 6'd20;
        @(negedge clk);
        chk("pre_wake_valid", -2, int'(io.issue_valid), 0);
        @(posedge clk); #1;
        io.p_commit = '0;
        n = 0;
        @(negedge clk);
        while (!io.issue_valid && n < 5) begin
            n++;
            @(negedge clk);
        end
        chk("wake_latency", -2, n, 0);
        chk("wake_issue_rd", -2, int'(io.issue.rd.idx), 50);
        $display("wake seq: extra_cycles=%0d issue_rd=%0d", n, io.issue.rd.idx);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
